stopwatch_counter: RTL
======================

// Module: stopwatch_counter
// PURPOSE
//  MM:SS BCD stopwatch core, downstream of the stopwatch clock divider.
//  Samples the divider's toggling 1 Hz / 2 Hz / 400 Hz levels in the sclk domain and turns them into single-cycle ticks.
//  Counts time, handles pause/clear buttons and the adjust switches, and feeds four BCD digits to the 7-seg mux.
// PARAMETERS
//  MIN_MAX         59  top minute value; MM wraps MIN_MAX -> 0
//  DEBOUNCE_TICKS  4   400 Hz ticks a button must stay stable (STOPWATCH_DEBOUNCE_EN only)
// PORTS
//  sclk       in   1  system clock (100 MHz)
//  rst        in   1  asynchronous, active-low reset
//  clk_1hz    in   1  divider level, toggles every 0.5 s; rising edge = count tick
//  clk_2hz    in   1  divider level; rising edge = adjust tick; level = blink phase
//  clk_400hz  in   1  divider level; rising edge = debounce sample tick
//  btn_pause  in   1  async button, press toggles run/pause
//  btn_clear  in   1  async button, press zeroes MM:SS
//  sw_adj     in   1  1 = adjust mode
//  sw_sel     in   1  adjust target: 0 = seconds, 1 = minutes
//  min_tens   out  4  BCD
//  min_ones   out  4  BCD
//  sec_tens   out  4  BCD
//  sec_ones   out  4  BCD
//  running    out  1  1 while in RUN state
//  blank_sel  out  1  sw_adj & ~clk_2hz level (sync'd); display blanks the selected field
// BEHAVIOUR
//  - rst low: all digits 0, running 0, state PAUSED, all sync/edge flops 0; takes effect immediately, mid-count included.
//  - Every async input passes through 2 flops. A tick is 1 sclk pulse on the 0->1 edge of the synchronized level.
//    Latency: input edge -> tick = 3 sclk; tick -> digit update = 1 sclk.
//  - States: PAUSED, RUN, ADJUST. Pause press: PAUSED<->RUN. sw_adj=1: ADJUST from either state.
//    sw_adj=0: back to the saved RUN/PAUSED. Pause presses in ADJUST are ignored.
//  - RUN, 1 Hz tick: sec_ones+1 with BCD carry; 9->0 carries into sec_tens; sec 59->00 carries into minutes.
//    Minutes: MIN_MAX -> 0 wrap with no overflow flag, so 59:59 -> 00:00.
//  - ADJUST, 2 Hz tick: selected field +1 mod 60 (mod MIN_MAX+1 for minutes). No carry into the other field. 1 Hz ticks are ignored.
//  - PAUSED: digits hold; all ticks ignored.
//  - Clear press zeroes all digits in any state. It outranks a tick in the same cycle and does not change state.
//  - Pause and clear pressed in the same cycle: both act (cleared and toggled).
//  - 1 Hz and 2 Hz ticks in the same cycle: only the tick relevant to the current state is used.
//  - running = (state==RUN); blank_sel = 0 outside ADJUST.
// CONFIGURATION
//  STOPWATCH_DEBOUNCE_EN defined:
//    A button press registers only after the synchronized level is high on DEBOUNCE_TICKS consecutive 400 Hz ticks.
//    The press is 1 pulse per stable rising edge; a bounce resets the count.
//  Undefined:
//    Press = rising edge of the 2-flop-synchronized level; clk_400hz is unused.
// STRUCTURE
//  stopwatch_pkg:
//    state enum {PAUSED, RUN, ADJUST}
//    BCD digit typedef (4 b)
//    SEC_MAX=59 and BCD_MAX=9 constants
//  Sub-module edge_sync (2-flop sync + rising-edge pulse): one instance per divider input and per button.
//  Core: state FSM + BCD counter chain, in one file.
// TESTING
//  1. Reset low mid-run at 12:34 -> digits 00:00, running=0 in the same cycle, without waiting for an sclk edge.
//  2. Pause press, then 5 clk_1hz rising edges -> 00:05, running=1. Pause again, 3 more edges -> still 00:05.
//  3. Preload 59:59 via adjust, RUN, one 1 Hz tick -> 00:00. From 00:09, one tick -> 00:10.
//  4. sw_adj=1, sw_sel=1, 3 clk_2hz edges from 58:30 -> 01:30 (wrap, seconds untouched). 1 Hz edges meanwhile do nothing.
//  5. Clear press on the same cycle as a 1 Hz tick at 07:41 -> 00:00, state stays RUN.
//  6. DEBOUNCE_EN, DEBOUNCE_TICKS=4: pause high for 3 400 Hz ticks then low -> no toggle. High for 4 ticks -> exactly one toggle.

Source files
------------

// File: rtl/stopwatch_counter_pkg.sv
// Shared state type, BCD digit type and BCD helpers for the MM:SS stopwatch core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEC_MAX = 7'd59;
  localparam bcd_t       BCD_MAX = 4'd9;

  function automatic logic [6:0] bcd_value(bcd_t tens, bcd_t ones);
    return {3'b000, tens} * 7'd10 + {3'b000, ones};
  endfunction

  // Two-digit BCD increment that wraps to 00 once the field reaches max_val.
  function automatic logic [7:0] bcd_wrap_inc(bcd_t tens, bcd_t ones, logic [6:0] max_val);
    logic [7:0] r;
    if (bcd_value(tens, ones) >= max_val) begin
      r = 8'h00;
    end else if (ones == BCD_MAX) begin
      r = {tens + 4'd1, 4'd0};
    end else begin
      r = {tens, ones + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Divider levels, buttons and switches in; BCD digits and status out of the stopwatch core.
interface stopwatch_counter_if;
  import stopwatch_pkg::*;

  logic clk_1hz;
  logic clk_2hz;
  logic clk_400hz;
  logic btn_pause;
  logic btn_clear;
  logic sw_adj;
  logic sw_sel;
  bcd_t min_tens;
  bcd_t min_ones;
  bcd_t sec_tens;
  bcd_t sec_ones;
  logic running;
  logic blank_sel;

  modport master (
    output clk_1hz, clk_2hz, clk_400hz, btn_pause, btn_clear, sw_adj, sw_sel,
    input  min_tens, min_ones, sec_tens, sec_ones, running, blank_sel
  );

  modport slave (
    input  clk_1hz, clk_2hz, clk_400hz, btn_pause, btn_clear, sw_adj, sw_sel,
    output min_tens, min_ones, sec_tens, sec_ones, running, blank_sel
  );

endinterface

// File: rtl/stopwatch_counter_edge_sync.sv
// Two-flop synchronizer plus a registered single-cycle pulse on the synchronized rising edge.
module edge_sync (
  input  logic sclk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;
  logic rise_d;

  always_comb rise_d = sync_q & ~prev_q;

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= rise_d;
    end
  end

  assign level = sync_q;
  assign rise  = rise_q;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch core: run/pause/adjust FSM and BCD counter chain.
// Define STOPWATCH_DEBOUNCE_EN to debounce the buttons on the 400 Hz tick.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int MIN_MAX        = 59,
  parameter int DEBOUNCE_TICKS = 4
) (
  input logic                sclk,
  input logic                rst,
  stopwatch_counter_if.slave sw
);

  localparam logic [6:0] MIN_LIMIT = 7'(MIN_MAX);

  logic tick_1hz, lvl_1hz;
  logic tick_2hz, lvl_2hz;
  logic pause_rise, pause_lvl;
  logic clear_rise, clear_lvl;
  logic adj_rise, adj_lvl;
  logic sel_rise, sel_lvl;
  logic press_pause, press_clear;
  logic unused_sigs;

  edge_sync u_sync_1hz   (.sclk(sclk), .rst(rst), .async_in(sw.clk_1hz),   .level(lvl_1hz),   .rise(tick_1hz));
  edge_sync u_sync_2hz   (.sclk(sclk), .rst(rst), .async_in(sw.clk_2hz),   .level(lvl_2hz),   .rise(tick_2hz));
  edge_sync u_sync_pause (.sclk(sclk), .rst(rst), .async_in(sw.btn_pause), .level(pause_lvl), .rise(pause_rise));
  edge_sync u_sync_clear (.sclk(sclk), .rst(rst), .async_in(sw.btn_clear), .level(clear_lvl), .rise(clear_rise));
  edge_sync u_sync_adj   (.sclk(sclk), .rst(rst), .async_in(sw.sw_adj),    .level(adj_lvl),   .rise(adj_rise));
  edge_sync u_sync_sel   (.sclk(sclk), .rst(rst), .async_in(sw.sw_sel),    .level(sel_lvl),   .rise(sel_rise));

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

  logic                  tick_400, lvl_400;
  logic [1:0]            btn_lvl;
  logic [1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]            press_q, press_d;

  edge_sync u_sync_400 (.sclk(sclk), .rst(rst), .async_in(sw.clk_400hz), .level(lvl_400), .rise(tick_400));

  assign btn_lvl = {clear_lvl, pause_lvl};

  // A low sample restarts the count; the press fires once as the count first reaches DEBOUNCE_TICKS.
  always_comb begin
    db_cnt_d = db_cnt_q;
    press_d  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (tick_400) begin
        if (!btn_lvl[i]) begin
          db_cnt_d[i] = '0;
        end else if (db_cnt_q[i] != CNT_W'(DEBOUNCE_TICKS)) begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
          press_d[i]  = (db_cnt_q[i] == CNT_W'(DEBOUNCE_TICKS - 1));
        end
      end
    end
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      db_cnt_q <= '0;
      press_q  <= 2'b00;
    end else begin
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_pause = press_q[0];
  assign press_clear = press_q[1];
  assign unused_sigs = ^{lvl_1hz, adj_rise, sel_rise, pause_rise, clear_rise, lvl_400};
`else
  assign press_pause = pause_rise;
  assign press_clear = clear_rise;
  assign unused_sigs = ^{lvl_1hz, adj_rise, sel_rise, pause_lvl, clear_lvl, sw.clk_400hz, DEBOUNCE_TICKS};
`endif

  sw_state_t  state_q, state_d;
  sw_state_t  saved_q, saved_d;
  sw_state_t  toggled;
  bcd_t       min_tens_q, min_tens_d;
  bcd_t       min_ones_q, min_ones_d;
  bcd_t       sec_tens_q, sec_tens_d;
  bcd_t       sec_ones_q, sec_ones_d;
  logic       running_q, running_d;
  logic       blank_q, blank_d;
  logic [7:0] sec_next;
  logic [7:0] min_next;

  // ADJUST remembers which of RUN/PAUSED to resume; pause presses are ignored while adjusting.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    toggled = (state_q == RUN) ? PAUSED : RUN;
    if (state_q == ADJUST) begin
      if (!adj_lvl) state_d = saved_q;
    end else begin
      if (!press_pause) toggled = state_q;
      if (adj_lvl) begin
        saved_d = toggled;
        state_d = ADJUST;
      end else begin
        state_d = toggled;
      end
    end
  end

  // Clear outranks any tick; only the tick belonging to the current state is honoured.
  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    sec_next   = bcd_wrap_inc(sec_tens_q, sec_ones_q, SEC_MAX);
    min_next   = bcd_wrap_inc(min_tens_q, min_ones_q, MIN_LIMIT);
    if (press_clear) begin
      min_tens_d = '0;
      min_ones_d = '0;
      sec_tens_d = '0;
      sec_ones_d = '0;
    end else if (state_q == RUN && tick_1hz) begin
      {sec_tens_d, sec_ones_d} = sec_next;
      if (bcd_value(sec_tens_q, sec_ones_q) >= SEC_MAX) begin
        {min_tens_d, min_ones_d} = min_next;
      end
    end else if (state_q == ADJUST && tick_2hz) begin
      if (sel_lvl) {min_tens_d, min_ones_d} = min_next;
      else         {sec_tens_d, sec_ones_d} = sec_next;
    end
    running_d = (state_d == RUN);
    blank_d   = (state_d == ADJUST) & ~lvl_2hz;
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q    <= PAUSED;
      saved_q    <= PAUSED;
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      running_q  <= 1'b0;
      blank_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      saved_q    <= saved_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      running_q  <= running_d;
      blank_q    <= blank_d;
    end
  end

  assign sw.min_tens  = min_tens_q;
  assign sw.min_ones  = min_ones_q;
  assign sw.sec_tens  = sec_tens_q;
  assign sw.sec_ones  = sec_ones_q;
  assign sw.running   = running_q;
  assign sw.blank_sel = blank_q;

endmodule
